// File: rtl/ge_p3_tobytes_pkg.sv
// ge_p3_tobytes_pkg: field constants, state types, inversion chain and fe_common helpers
package ge_p3_tobytes_pkg;
    localparam int LIMBS = 10;
    localparam int LW = 32;
    localparam int FW = LIMBS * LW;
    localparam int STEPS = 22;
    localparam logic [255:0] P = {1'b0, {247{1'b1}}, 8'hed};

    typedef enum logic [2:0] {IDLE, INV_GO, INV_WAIT, MUL_X, WAIT_X, MUL_Y, WAIT_Y, PACK} state_t;
    typedef enum logic [1:0] {I_IDLE, I_LOAD, I_WAIT} inv_state_t;

    // One chain step: dst = a*b, then dst = dst*dst for the remaining n-1 repetitions.
    // Register indices: 0=z, 1=t0, 2=t1, 3=t2, 4=t3 (t3 also receives the final result).
    typedef struct packed {
        logic [2:0] dst;
        logic [2:0] a;
        logic [2:0] b;
        logic [6:0] n;
    } step_t;

    // Bit offset of limb i in the 25.5-bit radix (26/25 alternating widths).
    function automatic int limb_off(input int i);
        return (i * 51 + 1) / 2;
    endfunction

    // Addition chain for z^(p-2): 254 squarings and 11 multiplies.
    function automatic step_t chain(input logic [4:0] i);
        step_t c;
        c = '0;
        case (i)
            5'd0:  c = {3'd1, 3'd0, 3'd0, 7'd1};
            5'd1:  c = {3'd2, 3'd1, 3'd1, 7'd2};
            5'd2:  c = {3'd2, 3'd0, 3'd2, 7'd1};
            5'd3:  c = {3'd1, 3'd1, 3'd2, 7'd1};
            5'd4:  c = {3'd3, 3'd1, 3'd1, 7'd1};
            5'd5:  c = {3'd2, 3'd2, 3'd3, 7'd1};
            5'd6:  c = {3'd3, 3'd2, 3'd2, 7'd5};
            5'd7:  c = {3'd2, 3'd3, 3'd2, 7'd1};
            5'd8:  c = {3'd3, 3'd2, 3'd2, 7'd10};
            5'd9:  c = {3'd3, 3'd3, 3'd2, 7'd1};
            5'd10: c = {3'd4, 3'd3, 3'd3, 7'd20};
            5'd11: c = {3'd3, 3'd4, 3'd3, 7'd1};
            5'd12: c = {3'd3, 3'd3, 3'd3, 7'd10};
            5'd13: c = {3'd2, 3'd3, 3'd2, 7'd1};
            5'd14: c = {3'd3, 3'd2, 3'd2, 7'd50};
            5'd15: c = {3'd3, 3'd3, 3'd2, 7'd1};
            5'd16: c = {3'd4, 3'd3, 3'd3, 7'd100};
            5'd17: c = {3'd3, 3'd4, 3'd3, 7'd1};
            5'd18: c = {3'd3, 3'd3, 3'd3, 7'd50};
            5'd19: c = {3'd2, 3'd3, 3'd2, 7'd1};
            5'd20: c = {3'd2, 3'd2, 3'd2, 7'd5};
            5'd21: c = {3'd4, 3'd2, 3'd1, 7'd1};
            default: c = '0;
        endcase
        return c;
    endfunction

    // Canonical little-endian encoding of an arbitrary (carried, >= p) limb vector.
    function automatic logic [255:0] fe_tobytes(input logic [FW-1:0] h);
        logic [263:0] v;
        logic [255:0] v1;
        logic [255:0] v2;
        v = '0;
        for (int i = 0; i < LIMBS; i++) v = v + (264'(h[LW*i +: LW]) << limb_off(i));
        v1 = {1'b0, v[254:0]} + 256'(v[263:255]) * 256'd19;
        v2 = {1'b0, v1[254:0]} + (v1[255] ? 256'd19 : 256'd0);
        return (v2 >= P) ? v2 - P : v2;
    endfunction

    // Sign of a field element: lowest bit of its canonical value.
    function automatic logic fe_isnegative(input logic [FW-1:0] h);
        logic [255:0] t;
        t = fe_tobytes(h);
        return t[0];
    endfunction
endpackage

// File: rtl/ge_p3_tobytes_if.sv
// ge_p3_tobytes_if: point input, encoded output and shared-multiplier port bundle
interface ge_p3_tobytes_if;
    logic [ge_p3_tobytes_pkg::FW-1:0] h_x;
    logic [ge_p3_tobytes_pkg::FW-1:0] h_y;
    logic [ge_p3_tobytes_pkg::FW-1:0] h_z;
    logic valid;
    logic [255:0] s;
    logic done;
    logic [ge_p3_tobytes_pkg::FW-1:0] mul_op_a;
    logic [ge_p3_tobytes_pkg::FW-1:0] mul_op_b;
    logic mul_valid;
    logic [ge_p3_tobytes_pkg::FW-1:0] mul_res;
    logic mul_done;

    modport master (
        output h_x, h_y, h_z, valid, mul_res, mul_done,
        input  s, done, mul_op_a, mul_op_b, mul_valid
    );
    modport slave (
        input  h_x, h_y, h_z, valid, mul_res, mul_done,
        output s, done, mul_op_a, mul_op_b, mul_valid
    );
endinterface

// File: rtl/ge_p3_tobytes_invert.sv
// fe_invert: z^(p-2) by a fixed addition chain over the shared multiplier
module fe_invert
    import ge_p3_tobytes_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [FW-1:0] z,
    output logic [FW-1:0] out,
    input  logic          valid,
    output logic          done,
    output logic [FW-1:0] pmul_in1,
    output logic [FW-1:0] pmul_in2,
    output logic          pmul_valid,
    input  logic [FW-1:0] mul_res,
    input  logic          mul_done
);
    inv_state_t st, nst;
    logic [FW-1:0] r [5];
    logic [4:0] step;
    logic [6:0] rep;
    step_t cur;
    logic ld, wr, last_rep, fin;

    assign cur = chain(step);

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= I_IDLE;
        else st <= nst;
    end

    // next state: load operands, wait for the product, repeat until the chain ends
    always_comb begin
        nst = (st == I_IDLE) ? (valid ? I_LOAD : I_IDLE)
            : (st == I_LOAD) ? I_WAIT
            : (mul_done ? (fin ? I_IDLE : I_LOAD) : I_WAIT);
    end

    // control decode
    always_comb begin
        ld = st == I_LOAD;
        wr = st == I_WAIT && mul_done;
        last_rep = rep == cur.n - 7'd1;
        fin = last_rep && step == 5'(STEPS - 1);
    end

    // chain registers, operand registers and product write-back
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 5; k++) r[k] <= '0;
            step <= '0;
            rep <= '0;
            out <= '0;
            done <= 1'b0;
            pmul_in1 <= '0;
            pmul_in2 <= '0;
            pmul_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            pmul_valid <= ld;
            if (st == I_IDLE && valid) begin
                r[0] <= z;
                step <= '0;
                rep <= '0;
            end
            if (ld) begin
                pmul_in1 <= (rep == 7'd0) ? r[cur.a] : r[cur.dst];
                pmul_in2 <= (rep == 7'd0) ? r[cur.b] : r[cur.dst];
            end
            if (wr) begin
                r[cur.dst] <= mul_res;
                rep <= last_rep ? 7'd0 : rep + 7'd1;
                if (last_rep) step <= step + 5'd1;
                if (fin) begin
                    out <= mul_res;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/ge_p3_tobytes.sv
// ge_p3_tobytes: compress an extended point (X:Y:Z) to its 32-byte Ed25519 encoding
module ge_p3_tobytes
    import ge_p3_tobytes_pkg::*;
(
    input  logic clk,
    input  logic rst,
    ge_p3_tobytes_if.slave bus
);
    state_t st, nst;
    logic [FW-1:0] hx, hy, hz, x, y, recip, lop_a, lop_b;
    logic [FW-1:0] inv_out, inv_a, inv_b;
    logic [255:0] s_q, ty;
    logic inv_en, local_valid, done_q, inv_valid, inv_done, inv_mvalid, accept, neg;

    fe_invert u_inv (
        .clk(clk),
        .rst(rst),
        .z(hz),
        .out(inv_out),
        .valid(inv_valid),
        .done(inv_done),
        .pmul_in1(inv_a),
        .pmul_in2(inv_b),
        .pmul_valid(inv_mvalid),
        .mul_res(bus.mul_res),
        .mul_done(bus.mul_done)
    );

    assign bus.s = s_q;
    assign bus.done = done_q;
    assign bus.mul_op_a = inv_en ? inv_a : lop_a;
    assign bus.mul_op_b = inv_en ? inv_b : lop_b;
    assign bus.mul_valid = local_valid | inv_mvalid;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= IDLE;
        else st <= nst;
    end

    // next state: invert Z, then X*Z^-1 and Y*Z^-1, then pack
    always_comb begin
        nst = st;
        unique case (st)
            IDLE:     nst = bus.valid ? INV_GO : IDLE;
            INV_GO:   nst = INV_WAIT;
            INV_WAIT: nst = inv_done ? MUL_X : INV_WAIT;
            MUL_X:    nst = WAIT_X;
            WAIT_X:   nst = bus.mul_done ? MUL_Y : WAIT_X;
            MUL_Y:    nst = WAIT_Y;
            WAIT_Y:   nst = bus.mul_done ? PACK : WAIT_Y;
            PACK:     nst = IDLE;
            default:  nst = IDLE;
        endcase
    end

    // control decode and packing of the affine coordinates
    always_comb begin
        accept = st == IDLE && bus.valid;
        inv_valid = st == INV_GO;
        ty = fe_tobytes(y);
        neg = fe_isnegative(x);
    end

    // datapath: input latch, multiplier requests, result capture and output encoding
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hx <= '0;
            hy <= '0;
            hz <= '0;
            x <= '0;
            y <= '0;
            recip <= '0;
            lop_a <= '0;
            lop_b <= '0;
            inv_en <= 1'b0;
            local_valid <= 1'b0;
            s_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            local_valid <= 1'b0;
            if (accept) begin
                hx <= bus.h_x;
                hy <= bus.h_y;
                hz <= bus.h_z;
            end
            case (st)
                INV_GO: inv_en <= 1'b1;
                INV_WAIT: if (inv_done) begin
                    recip <= inv_out;
                    inv_en <= 1'b0;
                end
                MUL_X: begin
                    lop_a <= hx;
                    lop_b <= recip;
                    local_valid <= 1'b1;
                end
                WAIT_X: if (bus.mul_done) x <= bus.mul_res;
                MUL_Y: begin
                    lop_a <= hy;
                    lop_b <= recip;
                    local_valid <= 1'b1;
                end
                WAIT_Y: if (bus.mul_done) y <= bus.mul_res;
                PACK: begin
                    s_q <= {ty[255] ^ neg, ty[254:0]};
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
